// File: rtl/id_imm_ctrl.sv
// Decode-stage immediate controller: classifies instr_d, drives immsrc to the extender and
// captures immediate/register fields into ID/EX with load-use stall and flush sequencing.
// Ports: clk, reset_n (async, active-low); IF/ID side instr_d/valid_d/ready_d;
//   extender side immsrc/ext_instr/immext; flush from EX; ID/EX side valid_e/ready_e,
//   imm_e, rd_e, rs1_e, rs2_e, opcode_e, illegal_e.
// Optional macro ID_STALL_CNT_EN adds stall_cnt[31:0] (non-flush stall cycles seen by IF/ID).
module id_imm_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr_d,
  input  logic        valid_d,
  output logic        ready_d,
  output logic [1:0]  immsrc,
  output logic [24:0] ext_instr,
  input  logic [31:0] immext,
  input  logic        flush,
  output logic        valid_e,
  input  logic        ready_e,
  output logic [31:0] imm_e,
  output logic [4:0]  rd_e,
  output logic [4:0]  rs1_e,
  output logic [4:0]  rs2_e,
  output logic [6:0]  opcode_e,
  output logic        illegal_e
`ifdef ID_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_ALUI  = 7'b0010011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;

  localparam logic [2:0] FC = 3'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    RUN,
    STALL,
    FLUSH
  } state_t;

  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;

  logic [6:0] op;
  logic [4:0] rd, rs1, rs2;
  logic       use1, use2, illegal, zero_imm;
  logic       hold, hz, accept;

  assign op        = instr_d[6:0];
  assign rd        = instr_d[11:7];
  assign rs1       = instr_d[19:15];
  assign rs2       = instr_d[24:20];
  assign ext_instr = instr_d[31:7];

  always_comb begin
    immsrc   = 2'b00;
    use1     = 1'b0;
    use2     = 1'b0;
    illegal  = 1'b0;
    zero_imm = 1'b0;
    unique case (1'b1)
      (op == OP_LOAD) || (op == OP_ALUI) || (op == OP_JALR): begin
        use1 = 1'b1;
      end
      (op == OP_STORE): begin
        immsrc = 2'b01;
        use1   = 1'b1;
        use2   = 1'b1;
      end
      (op == OP_BR): begin
        immsrc = 2'b10;
        use1   = 1'b1;
        use2   = 1'b1;
      end
      (op == OP_JAL): begin
        immsrc = 2'b11;
      end
      (op == OP_R): begin
        use1     = 1'b1;
        use2     = 1'b1;
        zero_imm = 1'b1;
      end
      default: begin
        illegal  = 1'b1;
        zero_imm = 1'b1;
      end
    endcase
  end

  assign hold = valid_e & ~ready_e;

  assign hz = valid_e & (opcode_e == OP_LOAD) & (rd_e != 5'd0) &
              ((use1 & (rs1 == rd_e)) | (use2 & (rs2 == rd_e)));

  assign ready_d = (state == RUN) & ~hold & ~hz & ~flush;
  assign accept  = valid_d & ready_d;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (flush) begin
      state_n = FLUSH;
      cnt_n   = FC;
    end else begin
      unique case (state)
        RUN:   if (hz && !hold) state_n = STALL;
        STALL: state_n = RUN;
        FLUSH: begin
          cnt_n = cnt - 3'd1;
          if (cnt == 3'd1) state_n = RUN;
        end
        default: state_n = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Flush beats hold: the wrong-path entry must never reach EX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_e   <= 1'b0;
      imm_e     <= 32'd0;
      rd_e      <= 5'd0;
      rs1_e     <= 5'd0;
      rs2_e     <= 5'd0;
      opcode_e  <= 7'd0;
      illegal_e <= 1'b0;
    end else if (flush) begin
      valid_e <= 1'b0;
    end else if (!hold) begin
      valid_e <= accept;
      if (accept) begin
        imm_e     <= zero_imm ? 32'd0 : immext;
        rd_e      <= rd;
        rs1_e     <= rs1;
        rs2_e     <= rs2;
        opcode_e  <= op;
        illegal_e <= illegal;
      end
    end
  end

`ifdef ID_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= 32'd0;
    end else if (valid_d && !ready_d && !flush && state != FLUSH) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_imm_ctrl.sv
// Self-checking bench for id_imm_ctrl: directed scenarios then randomized traffic,
// compared cycle by cycle against a behavioural model of the decode stage.
module tb_id_imm_ctrl;

  localparam int FC = 2;
  localparam int M_RUN = 0;
  localparam int M_STALL = 1;
  localparam int M_FLUSH = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr_d;
  logic        valid_d;
  logic        ready_d;
  logic [1:0]  immsrc;
  logic [24:0] ext_instr;
  logic [31:0] immext;
  logic        flush;
  logic        valid_e;
  logic        ready_e;
  logic [31:0] imm_e;
  logic [4:0]  rd_e, rs1_e, rs2_e;
  logic [6:0]  opcode_e;
  logic        illegal_e;
`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  id_imm_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .instr_d(instr_d),
    .valid_d(valid_d),
    .ready_d(ready_d),
    .immsrc(immsrc),
    .ext_instr(ext_instr),
    .immext(immext),
    .flush(flush),
    .valid_e(valid_e),
    .ready_e(ready_e),
    .imm_e(imm_e),
    .rd_e(rd_e),
    .rs1_e(rs1_e),
    .rs2_e(rs2_e),
    .opcode_e(opcode_e),
    .illegal_e(illegal_e)
`ifdef ID_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Extender stand-in, driven only by what the DUT hands it.
  always_comb begin
    unique case (immsrc)
      2'b00: immext = {{20{ext_instr[24]}}, ext_instr[24:13]};
      2'b01: immext = {{20{ext_instr[24]}}, ext_instr[24:18], ext_instr[4:0]};
      2'b10: immext = {{20{ext_instr[24]}}, ext_instr[0], ext_instr[23:18],
                       ext_instr[4:1], 1'b0};
      default: immext = {{12{ext_instr[24]}}, ext_instr[12:5], ext_instr[13],
                         ext_instr[23:14], 1'b0};
    endcase
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h want %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic bit uses1(input logic [6:0] op);
    case (op)
      7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h33: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit uses2(input logic [6:0] op);
    case (op)
      7'h23, 7'h63, 7'h33: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit is_ill(input logic [6:0] op);
    case (op)
      7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h33: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [1:0] src_of(input logic [6:0] op);
    case (op)
      7'h23: return 2'd1;
      7'h63: return 2'd2;
      7'h6F: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [31:0] exp_imm(input logic [31:0] i);
    int v;
    v = 0;
    case (i[6:0])
      7'h03, 7'h13, 7'h67: begin
        v = int'(i[31:20]);
        if (v >= 2048) v -= 4096;
      end
      7'h23: begin
        v = int'(i[31:25]) * 32 + int'(i[11:7]);
        if (v >= 2048) v -= 4096;
      end
      7'h63: begin
        v = int'(i[31]) * 4096 + int'(i[7]) * 2048 +
            int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      7'h6F: begin
        v = int'(i[31]) * (1 << 20) + int'(i[19:12]) * (1 << 12) +
            int'(i[20]) * 2048 + int'(i[30:21]) * 2;
        if (v >= (1 << 20)) v -= (1 << 21);
      end
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  bit          mv;
  int          mode, cnt;
  logic [31:0] e_imm;
  logic [4:0]  e_rd, e_rs1, e_rs2;
  logic [6:0]  e_op;
  logic        e_ill;
  logic [31:0] sc;
  logic        last_rdy;

  task automatic step(input logic [31:0] ins, input logic v,
                      input logic re, input logic fl);
    bit hold, hz, rdy;
    instr_d = ins;
    valid_d = v;
    ready_e = re;
    flush   = fl;
    #1;
    hold = mv && !re;
    hz = mv && e_op == 7'h03 && e_rd != 0 &&
         ((uses1(ins[6:0]) && ins[19:15] == e_rd) ||
          (uses2(ins[6:0]) && ins[24:20] == e_rd));
    rdy = mode == M_RUN && !hold && !hz && !fl;
    chk("ready_d", ready_d, rdy);
    chk("immsrc", immsrc, src_of(ins[6:0]));
    chk("ext_instr", ext_instr, ins[31:7]);
    last_rdy = ready_d;
    @(posedge clk);
    if (v && !rdy && !fl && mode != M_FLUSH) sc = sc + 1;
    if (fl) begin
      mv = 0;
      mode = M_FLUSH;
      cnt = FC;
    end else begin
      if (!hold) begin
        if (v && rdy) begin
          mv = 1;
          e_imm = exp_imm(ins);
          e_rd = ins[11:7];
          e_rs1 = ins[19:15];
          e_rs2 = ins[24:20];
          e_op = ins[6:0];
          e_ill = is_ill(ins[6:0]);
        end else begin
          mv = 0;
        end
      end
      case (mode)
        M_RUN: if (hz && !hold) mode = M_STALL;
        M_STALL: mode = M_RUN;
        default: begin
          cnt--;
          if (cnt == 0) mode = M_RUN;
        end
      endcase
    end
    @(negedge clk);
    chk("valid_e", valid_e, mv);
    if (mv) begin
      chk("imm_e", imm_e, e_imm);
      chk("rd_e", rd_e, e_rd);
      chk("rs1_e", rs1_e, e_rs1);
      chk("rs2_e", rs2_e, e_rs2);
      chk("opcode_e", opcode_e, e_op);
      chk("illegal_e", illegal_e, e_ill);
    end
`ifdef ID_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, sc);
`endif
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [6:0] ops [10];
    logic [31:0] r;
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h33, 7'h37, 7'h17, 7'h03};
    r = $urandom;
    r[24:20] = 5'($urandom_range(0, 3));
    r[19:15] = 5'($urandom_range(0, 3));
    r[11:7]  = 5'($urandom_range(0, 3));
    r[6:0]   = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
    return r;
  endfunction

  localparam logic [31:0] ADDI = 32'hFFF00093;
  localparam logic [31:0] SW   = 32'h0020A423;
  localparam logic [31:0] BEQ  = 32'hFE000EE3;
  localparam logic [31:0] LW5  = 32'h0000A283;
  localparam logic [31:0] ADD  = 32'h00528333;
  localparam logic [31:0] LW0  = 32'h0000A003;
  localparam logic [31:0] ADD0 = 32'h00000333;
  localparam logic [31:0] LUI  = 32'h000000B7;

  initial begin
    mv = 0; mode = M_RUN; cnt = 0;
    e_imm = 0; e_rd = 0; e_rs1 = 0; e_rs2 = 0; e_op = 0; e_ill = 0;
    sc = 0;
    reset_n = 1'b0;
    instr_d = ADDI;
    valid_d = 1'b1;
    ready_e = 1'b1;
    flush   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid_e", valid_e, 0);
    chk("rst_imm_e", imm_e, 0);
    chk("rst_rd_e", rd_e, 0);
    chk("rst_rs1_e", rs1_e, 0);
    chk("rst_rs2_e", rs2_e, 0);
    chk("rst_opcode_e", opcode_e, 0);
    chk("rst_illegal_e", illegal_e, 0);
`ifdef ID_STALL_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 0);
`endif
    reset_n = 1'b1;

    step(ADDI, 1, 1, 0);
    chk("addi_imm", imm_e, 32'hFFFFFFFF);
    chk("addi_rd", rd_e, 1);
    step(SW, 1, 1, 0);
    chk("sw_imm", imm_e, 32'h8);
    step(BEQ, 1, 1, 0);
    chk("beq_imm", imm_e, 32'hFFFFFFFC);

    step(LW5, 1, 1, 0);
    step(ADD, 1, 1, 0);
    chk("lu_stall", last_rdy, 0);
    chk("lu_bubble", valid_e, 0);
    step(ADD, 1, 1, 0);
    step(ADD, 1, 1, 0);
    chk("lu_accept", last_rdy, 1);
    chk("lu_rs1", rs1_e, 5);
    chk("lu_rs2", rs2_e, 5);
    step(LW0, 1, 1, 0);
    step(ADD0, 1, 1, 0);
    chk("x0_nostall", last_rdy, 1);

    step(ADDI, 1, 1, 0);
    repeat (3) begin
      step(SW, 1, 0, 0);
      chk("bp_rdy", last_rdy, 0);
      chk("bp_imm", imm_e, 32'hFFFFFFFF);
    end
    step(SW, 1, 1, 0);
    chk("bp_release", imm_e, 32'h8);

    step(BEQ, 1, 0, 1);
    chk("fl_valid", valid_e, 0);
    step(ADDI, 1, 1, 0);
    chk("fl_rdy1", last_rdy, 0);
    step(ADDI, 1, 1, 0);
    chk("fl_rdy2", last_rdy, 0);
    step(ADDI, 1, 1, 0);
    chk("fl_run", last_rdy, 1);
    step(ADDI, 1, 1, 1);
    step(ADDI, 1, 1, 0);
    step(ADDI, 1, 1, 1);
    step(ADDI, 1, 1, 0);
    step(ADDI, 1, 1, 0);
    chk("refl_rdy", last_rdy, 0);
    step(ADDI, 1, 1, 0);
    chk("refl_run", last_rdy, 1);

    step(LUI, 1, 1, 0);
    chk("lui_ill", illegal_e, 1);
    chk("lui_imm", imm_e, 0);

    repeat (3000) begin
      step(rnd_instr(), 1'($urandom_range(0, 4) != 0),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
